// File: rtl/pokey_mix_pkg.sv
// ----------------------------------------------------------------------------
// pokey_mix_pkg
// Shared widths, default tick divider and stage register layouts for the
// three-POKEY audio mixer and its sigma-delta DAC.
// ----------------------------------------------------------------------------
package pokey_mix_pkg;

    localparam int AUD_W       = 6;              // per-POKEY audio level width
    localparam int NCH         = 3;              // number of mixed channels
    localparam int SUM_W       = 8;              // 3 * 63 = 189 fits in 8 bits
    localparam int VOL_W       = 4;              // master volume 0..15
    localparam int PROD_W      = SUM_W + VOL_W;  // 189 * 15 = 2835 fits in 12 bits
    localparam int PCM_W       = 16;             // output sample width
    localparam int DIV_DEFAULT = 28;             // clk cycles per sample tick
    localparam int CNT_W       = 10;             // divider counter, DIV up to 1023

    // Stage 1: masked channel levels and the volume captured with them.
    typedef struct packed {
        logic [AUD_W-1:0] a0;
        logic [AUD_W-1:0] a1;
        logic [AUD_W-1:0] a2;
        logic [VOL_W-1:0] vol;
    } stage1_t;

    // Stage 2: channel sum travelling with its captured volume.
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [VOL_W-1:0] vol;
    } stage2_t;

endpackage

// File: rtl/pokey_mixer_if.sv
// ----------------------------------------------------------------------------
// pokey_mixer_if
// Audio bus between the POKEY sources and the mixer.
//   aud0..aud2 : 6-bit unsigned channel levels
//   en_mask    : per-channel enable, bit n gates audn
//   vol        : 4-bit master volume
//   pcm        : 16-bit mixed sample, held between updates
//   pcm_valid  : one-cycle pulse when pcm updates
//   dac_out    : 1-bit sigma-delta bitstream of pcm
// master = source side (drives levels), slave = mixer side.
// ----------------------------------------------------------------------------
interface pokey_mixer_if;
    import pokey_mix_pkg::*;

    logic [AUD_W-1:0] aud0;
    logic [AUD_W-1:0] aud1;
    logic [AUD_W-1:0] aud2;
    logic [NCH-1:0]   en_mask;
    logic [VOL_W-1:0] vol;
    logic [PCM_W-1:0] pcm;
    logic             pcm_valid;
    logic             dac_out;

    modport master (
        output aud0, aud1, aud2, en_mask, vol,
        input  pcm, pcm_valid, dac_out
    );

    modport slave (
        input  aud0, aud1, aud2, en_mask, vol,
        output pcm, pcm_valid, dac_out
    );

endinterface

// File: rtl/sd_dac1.sv
// ----------------------------------------------------------------------------
// sd_dac1
// First-order sigma-delta modulator. Each clk adds pcm into a 16-bit
// wrapping accumulator; the carry out is the registered output bit, so the
// density of ones equals pcm / 2^16.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   pcm     : 16-bit unsigned sample
//   dac_out : registered carry bitstream
// ----------------------------------------------------------------------------
module sd_dac1
    import pokey_mix_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PCM_W-1:0] pcm,
    output logic             dac_out
);

    logic [PCM_W-1:0] acc;
    logic [PCM_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, pcm};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            acc     <= acc_sum[PCM_W-1:0];
            dac_out <= acc_sum[PCM_W];
        end
    end

endmodule

// File: rtl/pokey_mixer.sv
// ----------------------------------------------------------------------------
// pokey_mixer
// Mixes three POKEY audio levels into a 16-bit PCM sample once per DIV clk
// cycles and drives a 1-bit sigma-delta DAC from it.
//   clk     : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pokey_mixer_if.slave (levels/mask/vol in, pcm/valid/dac out)
// Pipeline: tick -> capture (stage 1) -> sum (stage 2) -> scale into pcm
// (stage 3). A tick in cycle t shows pcm_valid in cycle t+3. DIV must be
// 4..1023 so a sample drains before the next tick; there is no back-pressure.
// ----------------------------------------------------------------------------
module pokey_mixer
    import pokey_mix_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
)
(
    input logic          clk,
    input logic          reset_n,
    pokey_mixer_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam int               PAD_W    = PCM_W - PROD_W;

    // ---------------- tick divider ----------------
    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and pipeline stages advance in lock-step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // ---------------- stage 1: capture ----------------
    stage1_t s1;
    logic    s1_valid;

    // NOTE: data registers are reset as well as valid flags, so pcm reads 0
    // the moment reset asserts rather than holding a stale sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1.a0  <= bus.en_mask[0] ? bus.aud0 : '0;
                s1.a1  <= bus.en_mask[1] ? bus.aud1 : '0;
                s1.a2  <= bus.en_mask[2] ? bus.aud2 : '0;
                s1.vol <= bus.vol;
            end
        end
    end

    // ---------------- stage 2: sum ----------------
    stage2_t s2;
    logic    s2_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2       <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2.sum <= SUM_W'(s1.a0) + SUM_W'(s1.a1) + SUM_W'(s1.a2);
                s2.vol <= s1.vol;
            end
        end
    end

    // ---------------- stage 3: scale ----------------
    logic [PROD_W-1:0] product;
    logic [PCM_W-1:0]  pcm_q;
    logic              pcm_valid_q;

    assign product = PROD_W'(s2.sum) * PROD_W'(s2.vol);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            pcm_valid_q <= s2_valid;
            if (s2_valid) begin
                pcm_q <= {product, {PAD_W{1'b0}}};
            end
        end
    end

    // ---------------- sigma-delta DAC ----------------
    logic dac_bit;

    sd_dac1 u_sd_dac1 (
        .clk     (clk),
        .reset_n (reset_n),
        .pcm     (pcm_q),
        .dac_out (dac_bit)
    );

    assign bus.pcm       = pcm_q;
    assign bus.pcm_valid = pcm_valid_q;
    assign bus.dac_out   = dac_bit;

endmodule

// File: tb/tb_pokey_mixer.sv
// ----------------------------------------------------------------------------
// tb_pokey_mixer
// Directed bench for pokey_mixer: reset behaviour, tick-to-valid latency,
// channel masking, volume scaling, input hold between ticks, sigma-delta
// density and reset in mid-pipeline.
// ----------------------------------------------------------------------------
module tb_pokey_mixer;
    import pokey_mix_pkg::*;

    localparam int DIV = DIV_DEFAULT;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pokey_mixer_if bus ();

    pokey_mixer #(.DIV(DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Hard stop in case a wait escapes its own bound.
    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                              input logic [2:0] m, input logic [3:0] v);
        bus.aud0    = a0;
        bus.aud1    = a1;
        bus.aud2    = a2;
        bus.en_mask = m;
        bus.vol     = v;
    endtask

    // Advance one rising edge at a time (sampling at the following falling
    // edge) until pcm_valid is seen; report how many rising edges it took.
    task automatic wait_valid(output int edges, output bit found);
        edges = 0;
        found = 1'b0;
        while (!found && edges < 4 * DIV) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.pcm_valid === 1'b1) found = 1'b1;
        end
    endtask

    // Full-scale sample straight out of reset: latency and pulse shape.
    task automatic test_full_scale();
        int e;
        bit f;
        set_inputs(6'd63, 6'd63, 6'd63, 3'b111, 4'd15);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        // Divider counts 0..DIV-1 from release; capture on edge DIV, pcm on edge DIV+2.
        wait_valid(e, f);
        n_checks++;
        if (!f || e !== DIV + 2)
            $display("FAIL first_latency: edges=%0d seen=%0d, required edges=%0d", e, f, DIV + 2);
        else n_pass++;
        n_checks++;
        if (bus.pcm !== 16'hB130) $display("FAIL full_scale_pcm: got %h, required b130", bus.pcm);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.pcm_valid !== 1'b0) $display("FAIL valid_pulse_width: pcm_valid=%b one cycle later, required 0", bus.pcm_valid);
        else n_pass++;
        wait_valid(e, f);
        n_checks++;
        if (!f || e !== DIV - 1) $display("FAIL sample_period: edges=%0d seen=%0d, required %0d", e, f, DIV - 1);
        else n_pass++;
        n_checks++;
        if (bus.pcm !== 16'hB130) $display("FAIL full_scale_repeat: got %h, required b130", bus.pcm);
        else n_pass++;
    endtask

    // Asynchronous clear, then held low while all inputs toggle.
    task automatic test_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pcm !== 16'h0000 || bus.pcm_valid !== 1'b0 || bus.dac_out !== 1'b0)
            $display("FAIL reset_async: pcm=%h valid=%b dac=%b, required 0000/0/0",
                     bus.pcm, bus.pcm_valid, bus.dac_out);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_inputs(6'($urandom), 6'($urandom), 6'($urandom), 3'($urandom), 4'($urandom));
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.pcm !== 16'h0000 || bus.pcm_valid !== 1'b0 || bus.dac_out !== 1'b0)
                $display("FAIL reset_hold[%0d]: pcm=%h valid=%b dac=%b, required 0000/0/0",
                         i, bus.pcm, bus.pcm_valid, bus.dac_out);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sync to a sample boundary, apply one vector, check the next sample.
    task automatic sample(input string name, input logic [5:0] a0, input logic [5:0] a1,
                          input logic [5:0] a2, input logic [2:0] m, input logic [3:0] v,
                          input logic [15:0] exp_pcm);
        int e;
        bit f;
        wait_valid(e, f);
        n_checks++;
        if (!f) $display("FAIL %s_sync: no pcm_valid within %0d edges", name, 4 * DIV);
        else n_pass++;
        set_inputs(a0, a1, a2, m, v);
        wait_valid(e, f);
        n_checks++;
        if (!f || e !== DIV) $display("FAIL %s_period: edges=%0d seen=%0d, required %0d", name, e, f, DIV);
        else n_pass++;
        n_checks++;
        if (bus.pcm !== exp_pcm) $display("FAIL %s_pcm: got %h, required %h", name, bus.pcm, exp_pcm);
        else n_pass++;
    endtask

    // Inputs scrambled between ticks but restored before capture must not
    // disturb the held pcm or the next sample. Expects inputs already at
    // (20,30,40,110,7) -> 70*7 = 490 = 0x1EA -> 0x1EA0.
    task automatic test_hold_between_ticks();
        int e;
        bit f;
        wait_valid(e, f);
        for (int k = 0; k < DIV - 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            set_inputs(~6'd20, ~6'd30, ~6'd40, ~3'b110, ~4'd7);
            n_checks++;
            if (bus.pcm !== 16'h1EA0 || bus.pcm_valid !== 1'b0)
                $display("FAIL hold_between[%0d]: pcm=%h valid=%b, required 1ea0/0", k, bus.pcm, bus.pcm_valid);
            else n_pass++;
        end
        set_inputs(6'd20, 6'd30, 6'd40, 3'b110, 4'd7);
        wait_valid(e, f);
        n_checks++;
        if (!f || e !== 4) $display("FAIL hold_next_valid: edges=%0d seen=%0d, required 4", e, f);
        else n_pass++;
        n_checks++;
        if (bus.pcm !== 16'h1EA0) $display("FAIL hold_next_pcm: got %h, required 1ea0", bus.pcm);
        else n_pass++;
    endtask

    // vol = 0 gives pcm = 0, which must keep dac_out low.
    task automatic test_vol_zero();
        int ones = 0;
        sample("vol_zero", 6'd63, 6'd63, 6'd63, 3'b111, 4'd0, 16'h0000);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.dac_out === 1'b1) ones++;
        end
        n_checks++;
        if (ones !== 0) $display("FAIL dac_zero: %0d ones in 1000 cycles, required 0", ones);
        else n_pass++;
    endtask

    // Constant pcm = 0xB130: 65536 cycles must hold exactly 45360 ones.
    task automatic test_sigma_delta();
        int ones = 0;
        int pcm_changes = 0;
        sample("sd_full", 6'd63, 6'd63, 6'd63, 3'b111, 4'd15, 16'hB130);
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (bus.dac_out === 1'b1) ones++;
            if (bus.pcm !== 16'hB130) pcm_changes++;
        end
        n_checks++;
        if (ones !== 45360) $display("FAIL dac_density: %0d ones in 65536 cycles, required 45360", ones);
        else n_pass++;
        n_checks++;
        if (pcm_changes !== 0) $display("FAIL sd_pcm_const: %0d cycles off b130, required 0", pcm_changes);
        else n_pass++;
    endtask

    // One-cycle reset just after a capture: that sample is dropped and the
    // next valid comes from a fresh divider count (capture on edge DIV,
    // pcm on edge DIV+2 after release).
    task automatic test_reset_mid();
        int e;
        bit f;
        sample("pre_mid", 6'd1, 6'd2, 6'd3, 3'b111, 4'd2, 16'h00C0);
        set_inputs(6'd63, 6'd63, 6'd63, 3'b111, 4'd1);
        repeat (DIV - 2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pcm !== 16'h0000) $display("FAIL mid_reset_clear: pcm=%h, required 0000", bus.pcm);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        wait_valid(e, f);
        n_checks++;
        if (!f || e !== DIV + 2)
            $display("FAIL mid_reset_latency: edges=%0d seen=%0d, required %0d", e, f, DIV + 2);
        else n_pass++;
        n_checks++;
        if (bus.pcm !== 16'h0BD0) $display("FAIL mid_reset_pcm: got %h, required 0bd0", bus.pcm);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        set_inputs('0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        test_full_scale();
        test_reset();
        // 10 * 1 = 10 -> 0x0A0; masked channels contribute nothing.
        sample("mask_010", 6'd63, 6'd10, 6'd63, 3'b010, 4'd1, 16'h00A0);
        // (1+2+3) * 2 = 12 -> 0x0C0
        sample("small_sum", 6'd1, 6'd2, 6'd3, 3'b111, 4'd2, 16'h00C0);
        // (63+63) * 15 = 1890 = 0x762 -> 0x7620
        sample("mask_101", 6'd63, 6'd63, 6'd63, 3'b101, 4'd15, 16'h7620);
        // all channels masked -> 0
        sample("mask_000", 6'd63, 6'd63, 6'd63, 3'b000, 4'd15, 16'h0000);
        // (20+30) * 7 = 350... with mask 110: 30+40 = 70 * 7 = 490 = 0x1EA
        sample("mask_110", 6'd20, 6'd30, 6'd40, 3'b110, 4'd7, 16'h1EA0);
        test_hold_between_ticks();
        test_vol_zero();
        test_sigma_delta();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pokey_mixer.md
POKEY_MIXER -- requirements
Module: pokey_mixer

Interface
REQ-001 Parameter DIV, default 28, clk cycles per audio sample tick; legal range 4..1023.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 aud0  input  6  audio level from pokey 0, unsigned.
REQ-005 aud1  input  6  audio level from pokey 1, unsigned.
REQ-006 aud2  input  6  audio level from pokey 2, unsigned.
REQ-007 en_mask  input  3  per-channel enable; bit n gates audn.
REQ-008 vol  input  4  master volume, unsigned 0..15.
REQ-009 pcm  output  16  mixed sample, unsigned, held between updates.
REQ-010 pcm_valid  output  1  one-cycle pulse when pcm updates.
REQ-011 dac_out  output  1  first-order sigma-delta bitstream of pcm.

Function
REQ-012 Tick divider SHALL count 0..DIV-1 and wrap to 0; tick asserts for one cycle when count = DIV-1.
REQ-013 Stage 1, on tick: capture audn masked by en_mask[n] (masked channel reads 0) and capture vol into sample registers.
REQ-014 Stage 2, cycle after stage 1: sum = a0+a1+a2, 8-bit unsigned (max 189, no overflow).
REQ-015 Stage 3, cycle after stage 2: product = sum*vol_captured, 12-bit unsigned (max 2835); pcm = {product, 4'b0000}.
REQ-016 pcm_valid SHALL pulse in the same cycle pcm loads; tick in cycle t gives pcm_valid high in cycle t+3.
REQ-017 Inputs and vol changing between ticks SHALL NOT affect pcm; only tick-captured values are used.
REQ-018 Stage valid flags SHALL propagate with the data; no pcm_valid without a preceding tick.
REQ-019 Sigma-delta: 16-bit accumulator; every clk, {carry, acc} = acc + pcm (17-bit); dac_out registered = carry.
REQ-020 Accumulator wraps modulo 2^16; over any 65536 consecutive cycles with constant pcm, count of dac_out ones SHALL equal pcm exactly.
REQ-021 pcm = 0 SHALL hold dac_out at 0; pcm never reaches 0xFFFF (max 0xB130).
REQ-022 DIV >= 4 guarantees the pipeline drains before the next tick; no back-pressure exists.

Reset
REQ-023 reset_n low SHALL immediately clear divider, stage registers, valid flags, accumulator: pcm=0, pcm_valid=0, dac_out=0.
REQ-024 Reset mid-pipeline SHALL discard in-flight samples; no pcm_valid for them after release.
REQ-025 After release, first tick SHALL occur DIV cycles after the first clk edge with reset_n high.

Structure
REQ-026 Package pokey_mix_pkg SHALL hold AUD_W=6, NCH=3, SUM_W=8, VOL_W=4, PCM_W=16, and DIV default.
REQ-027 Sigma-delta modulator SHALL be sub-module sd_dac1 (inputs clk, reset_n, pcm; output dac_out).
REQ-028 Divider and three-stage mix pipeline SHALL stay in pokey_mixer; no other sub-modules.

Verification
REQ-029 Hold reset_n low, toggle all inputs -> pcm=0x0000, pcm_valid=0, dac_out=0 throughout.
REQ-030 aud0=aud1=aud2=63, en_mask=3'b111, vol=15 -> pcm=0xB130 with pcm_valid exactly 3 cycles after tick.
REQ-031 aud1=10, aud0=aud2=63, en_mask=3'b010, vol=1 -> pcm=0x00A0.
REQ-032 vol=0, all aud=63 -> pcm=0x0000, dac_out stays 0 for 1000 cycles.
REQ-033 Constant pcm=0xB130, count dac_out ones over 65536 cycles -> exactly 45360.
REQ-034 Pulse reset_n low 1 cycle after a tick -> no pcm_valid for that sample; next pcm_valid DIV+3 cycles after release.
